lectura_rtc: RTL

LECTURA_RTC -- requirements
Module: lectura_rtc

---
 rtl/lectura_rtc_pkg.sv | 29 ++
 rtl/lectura_rtc_if.sv | 29 ++
 rtl/lectura_rtc_contador_espera.sv | 44 ++++
 rtl/lectura_rtc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lectura_rtc_pkg.sv
// lectura_defs: shared definitions for the RTC register reader.
//   - estado_t      : reader FSM state encodings
//   - CTRL_*        : Control mode encodings
//   - *_DEF         : default N_REG, DIR_BASE and T_ESPERA values
//   - es_bcd()      : true when both nibbles of a byte are 0..9
package lectura_defs;

    typedef enum logic [2:0] {
        REPOSO  = 3'd0,
        PEDIR   = 3'd1,
        ESPERAR = 3'd2,
        GUARDAR = 3'd3,
        FIN     = 3'd4
    } estado_t;

    localparam logic [1:0] CTRL_REPOSO   = 2'b00;
    localparam logic [1:0] CTRL_UNICO    = 2'b01;
    localparam logic [1:0] CTRL_CONTINUO = 2'b10;
    localparam logic [1:0] CTRL_CONGELAR = 2'b11;

    localparam int         N_REG_DEF    = 6;
    localparam logic [7:0] DIR_BASE_DEF = 8'h21;
    localparam int         T_ESPERA_DEF = 16;

    function automatic logic es_bcd(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/lectura_rtc_if.sv
// lectura_rtc_if: read bus between the reader (master) and the RTC (slave).
//   Direccion : register address, valid while req_bus is high
//   req_bus   : read request, held high until ack_bus or until the reader
//               gives up on a timeout
//   ack_bus   : one-cycle acknowledge; Dato_in is valid in the same cycle
//               and is only taken while the reader is waiting
//   Dato_in   : byte returned by the RTC
interface lectura_rtc_if;

    logic [7:0] Direccion;
    logic       req_bus;
    logic       ack_bus;
    logic [7:0] Dato_in;

    modport master (
        output Direccion,
        output req_bus,
        input  ack_bus,
        input  Dato_in
    );

    modport slave (
        input  Direccion,
        input  req_bus,
        output ack_bus,
        output Dato_in
    );

endinterface

// File: rtl/lectura_rtc_contador_espera.sv
// contador_espera: acknowledge-wait counter.
//   reloj      : clock (rising edge)
//   resetM     : synchronous active-high reset
//   clear      : reload the count with zero (wins over enable)
//   enable     : count one wait cycle
//   fin_cuenta : high while the count equals T_ESPERA-1
module contador_espera
    import lectura_defs::*;
#(
    parameter int T_ESPERA = T_ESPERA_DEF
) (
    input  logic reloj,
    input  logic resetM,
    input  logic clear,
    input  logic enable,
    output logic fin_cuenta
);

    localparam int CW = (T_ESPERA > 1) ? $clog2(T_ESPERA) : 1;

    logic [CW-1:0] cuenta_q;
    logic [CW-1:0] cuenta_d;

    assign fin_cuenta = (cuenta_q == CW'(T_ESPERA - 1));

    // Saturate at the terminal count so the flag stays up until cleared.
    always_comb begin
        cuenta_d = cuenta_q;
        if (clear) begin
            cuenta_d = '0;
        end else if (enable && !fin_cuenta) begin
            cuenta_d = cuenta_q + CW'(1);
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

endmodule

// File: rtl/lectura_rtc.sv
// lectura_rtc: sweeps N_REG consecutive RTC registers starting at DIR_BASE
// and publishes them together once the whole sweep has been read.
//   reloj         : clock (rising edge)
//   resetM        : synchronous active-high reset
//   Control       : 00 idle, 01 single sweep, 10 continuous, 11 hold
//   inicio        : one-cycle start strobe, accepted only in REPOSO
//   bus           : read bus (master side), see lectura_rtc_if
//   Registros     : captured bytes, register i at [8i+7:8i]
//   listo         : one-cycle pulse when a sweep completes without error
//   error_lectura : sticky; cleared by reset or by the next accepted start
//   estado_dbg    : current FSM state
// Build option: LECTURA_BCD_CHECK_EN rejects bytes with a nibble above 9.
module lectura_rtc
    import lectura_defs::*;
#(
    parameter int         N_REG    = N_REG_DEF,
    parameter logic [7:0] DIR_BASE = DIR_BASE_DEF,
    parameter int         T_ESPERA = T_ESPERA_DEF
) (
    input  logic               reloj,
    input  logic               resetM,
    input  logic [1:0]         Control,
    input  logic               inicio,
    lectura_rtc_if.master      bus,
    output logic [8*N_REG-1:0] Registros,
    output logic               listo,
    output logic               error_lectura,
    output estado_t            estado_dbg
);

    localparam int IW = (N_REG > 1) ? $clog2(N_REG) : 1;

    estado_t            estado_q,    estado_d;
    logic [IW-1:0]      indice_q,    indice_d;
    logic [7:0]         direccion_q, direccion_d;
    logic               req_q,       req_d;
    logic               listo_q,     listo_d;
    logic               error_q,     error_d;
    logic [7:0]         byte_q,      byte_d;
    logic [8*N_REG-1:0] banco_q,     banco_d;
    logic [8*N_REG-1:0] registros_q, registros_d;

    logic               cnt_clear;
    logic               cnt_enable;
    logic               fin_cuenta;
    logic [8*N_REG-1:0] banco_w;
    logic               ultimo;
    logic               byte_ok;

    contador_espera #(
        .T_ESPERA (T_ESPERA)
    ) u_contador_espera (
        .reloj      (reloj),
        .resetM     (resetM),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .fin_cuenta (fin_cuenta)
    );

    // All outputs are registered, so the values shown during a state are
    // loaded on the edge that enters it. In particular the bank copy and
    // the listo pulse are loaded on the GUARDAR->FIN edge, which makes
    // them visible together during FIN.
    always_comb begin
        estado_d    = estado_q;
        indice_d    = indice_q;
        direccion_d = direccion_q;
        req_d       = req_q;
        listo_d     = 1'b0;
        error_d     = error_q;
        byte_d      = byte_q;
        banco_d     = banco_q;
        registros_d = registros_q;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;

        banco_w = banco_q;
        for (int i = 0; i < N_REG; i++) begin
            if (indice_q == IW'(i)) begin
                banco_w[8*i +: 8] = byte_q;
            end
        end
        ultimo = (indice_q == IW'(N_REG - 1));
`ifdef LECTURA_BCD_CHECK_EN
        byte_ok = es_bcd(byte_q);
`else
        byte_ok = 1'b1;
`endif

        case (estado_q)
            REPOSO: begin
                if (inicio && (Control == CTRL_UNICO || Control == CTRL_CONTINUO)) begin
                    estado_d    = PEDIR;
                    indice_d    = '0;
                    direccion_d = DIR_BASE;
                    req_d       = 1'b1;
                    error_d     = 1'b0;
                end
            end
            PEDIR: begin
                cnt_clear = 1'b1;
                if (Control == CTRL_REPOSO) begin
                    estado_d = REPOSO;
                    req_d    = 1'b0;
                end else begin
                    estado_d = ESPERAR;
                end
            end
            ESPERAR: begin
                cnt_enable = 1'b1;
                if (Control == CTRL_REPOSO) begin
                    estado_d = REPOSO;
                    req_d    = 1'b0;
                end else if (bus.ack_bus) begin
                    byte_d   = bus.Dato_in;
                    req_d    = 1'b0;
                    estado_d = GUARDAR;
                end else if (fin_cuenta) begin
                    error_d  = 1'b1;
                    req_d    = 1'b0;
                    estado_d = REPOSO;
                end
            end
            GUARDAR: begin
                if (!byte_ok) begin
                    error_d  = 1'b1;
                    estado_d = REPOSO;
                end else begin
                    banco_d = banco_w;
                    if (ultimo) begin
                        estado_d = FIN;
                        listo_d  = 1'b1;
                        // Hold mode freezes the published copy only.
                        if (Control != CTRL_CONGELAR) begin
                            registros_d = banco_w;
                        end
                    end else begin
                        indice_d    = indice_q + IW'(1);
                        direccion_d = DIR_BASE + 8'(indice_q + IW'(1));
                        req_d       = 1'b1;
                        estado_d    = PEDIR;
                    end
                end
            end
            FIN: begin
                indice_d = '0;
                if (Control == CTRL_CONTINUO) begin
                    estado_d    = PEDIR;
                    direccion_d = DIR_BASE;
                    req_d       = 1'b1;
                end else begin
                    estado_d = REPOSO;
                end
            end
            default: begin
                estado_d = REPOSO;
                req_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            estado_q    <= REPOSO;
            indice_q    <= '0;
            direccion_q <= 8'h00;
            req_q       <= 1'b0;
            listo_q     <= 1'b0;
            error_q     <= 1'b0;
            byte_q      <= 8'h00;
            banco_q     <= '0;
            registros_q <= '0;
        end else begin
            estado_q    <= estado_d;
            indice_q    <= indice_d;
            direccion_q <= direccion_d;
            req_q       <= req_d;
            listo_q     <= listo_d;
            error_q     <= error_d;
            byte_q      <= byte_d;
            banco_q     <= banco_d;
            registros_q <= registros_d;
        end
    end

    assign bus.Direccion  = direccion_q;
    assign bus.req_bus    = req_q;
    assign Registros      = registros_q;
    assign listo          = listo_q;
    assign error_lectura  = error_q;
    assign estado_dbg     = estado_q;

endmodule
